// File: rtl/tick_period_meter.sv
// Measures the period and high time of a slow tick sampled in the clk domain.
// It reports lock once the period is stable, and a sticky timeout when edges stop arriving.
module tick_period_meter #(
  parameter int unsigned N           = 28,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         tick_in,
  input  logic [N-1:0] max_period,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LockMax = MW'(LOCK_CNT);
  localparam logic [N-1:0] CntMax = {N{1'b1}};
  localparam logic [N-1:0] CntOne = N'(1);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  state_e            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              s, s_d_q, rise;
  logic [N-1:0]      cnt_q, cnt_d;
  logic [N-1:0]      hcnt_q, hcnt_d;
  logic [N-1:0]      period_q, period_d;
  logic [N-1:0]      high_q, high_d;
  logic [MW-1:0]     match_q, match_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // The synchronizer keeps running while disabled so re-enable sees a settled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      s_d_q  <= s;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (!en) begin
      // Results are kept on display; everything else restarts.
      state_d   = StIdle;
      cnt_d     = '0;
      hcnt_d    = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm: begin
          if (rise) begin
            state_d = StMeas;
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
          end
        end
        StMeas: begin
          if (rise) begin
            // A rise on the compare cycle wins over timeout.
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            cnt_d     = CntOne;
            hcnt_d    = CntOne;
            timeout_d = 1'b0;
            if (match_q != '0 && cnt_q == period_q) begin
              match_d = (match_q == LockMax) ? LockMax : match_q + MW'(1);
            end else begin
              match_d = MW'(1);
            end
            locked_d = (match_d == LockMax);
          end else if (max_period != '0 && cnt_q == max_period) begin
            state_d   = StArm;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
            if (s && hcnt_q != CntMax) begin
              hcnt_d = hcnt_q + CntOne;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: expected measurements are queued as pulses are
// driven and checked against each period_valid pulse.
module tb_tick_period_meter;

  localparam int unsigned N = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         tick_in;
  logic [N-1:0] max_period;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  tick_period_meter #(.N(N), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tick_in      (tick_in),
    .max_period   (max_period),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] p;
    logic [N-1:0] h;
    logic         l;
    bit           chk_gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input int p, input int h, input bit l, input bit g);
    exp_t e;
    e.p = N'(p);
    e.h = N'(h);
    e.l = l;
    e.chk_gap = g;
    sb.push_back(e);
  endtask

  // Rise starts the pulse; consecutive rises are hi+lo cycles apart.
  task automatic pulse(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic train(input int sp, input int hi, input int n);
    for (int i = 0; i < n; i++) pulse(hi, sp - hi);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_high"}, 64'(high_time), 64'd0);
    check({tag, "_valid"}, 64'(period_valid), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && period_valid) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_period", 64'(period), 64'(e.p));
        check("sb_high", 64'(high_time), 64'(e.h));
        check("sb_locked", 64'(locked), 64'(e.l));
        check("sb_timeout", 64'(timeout), 64'd0);
        if (e.chk_gap) check("sb_gap", 64'(cyc - last_valid_cyc), 64'(e.p));
      end
      last_valid_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst = 1'b1;
    en = 1'b0;
    tick_in = 1'b0;
    max_period = '0;

    // Reset held with tick toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick_in = ~tick_in;
    end
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tick_in = ~tick_in;
    end
    check_all_zero("en_off");
    tick_in = 1'b0;
    repeat (4) @(negedge clk);

    // Pulses every 10, then lock
    en = 1'b1;
    repeat (3) @(negedge clk);
    expect_v(10, 1, 0, 0); expect_v(10, 1, 0, 1); expect_v(10, 1, 0, 1);
    expect_v(10, 1, 1, 1); expect_v(10, 1, 1, 1);
    train(10, 1, 6);

    // Switch to 11: lock drops, returns after the 4th consecutive 11
    expect_v(10, 1, 1, 1); expect_v(11, 1, 0, 1); expect_v(11, 1, 0, 1);
    expect_v(11, 1, 0, 1); expect_v(11, 1, 1, 1);
    train(11, 1, 5);

    // Square wave 6/6
    expect_v(11, 1, 1, 1); expect_v(12, 6, 0, 1); expect_v(12, 6, 0, 1);
    expect_v(12, 6, 0, 1); expect_v(12, 6, 1, 1);
    train(12, 6, 5);

    // Timeout after pulses stop
    max_period = N'(20);
    expect_v(12, 6, 1, 1); expect_v(10, 1, 0, 1); expect_v(10, 1, 0, 1);
    expect_v(10, 1, 0, 1); expect_v(10, 1, 1, 1);
    train(10, 1, 5);
    d = 0;
    while (!timeout && d < 40) begin
      @(negedge clk);
      d++;
    end
    check("to_set", 64'(timeout), 64'd1);
    check("to_delay", 64'(cyc - last_valid_cyc), 64'd20);
    check("to_locked", 64'(locked), 64'd0);
    check("to_period_hold", 64'(period), 64'd10);
    check("to_high_hold", 64'(high_time), 64'd1);

    // Resume: first rise only re-arms, second clears timeout
    train(10, 1, 1);
    check("to_sticky", 64'(timeout), 64'd1);
    check("to_arm_period", 64'(period), 64'd10);
    expect_v(10, 1, 0, 0); expect_v(10, 1, 0, 1); expect_v(10, 1, 0, 1);
    train(10, 1, 3);
    check("to_cleared", 64'(timeout), 64'd0);

    // Rise on the compare cycle wins
    expect_v(10, 1, 1, 1); expect_v(20, 1, 0, 1); expect_v(20, 1, 0, 1);
    expect_v(20, 1, 0, 1); expect_v(20, 1, 1, 1);
    train(20, 1, 5);
    check("edge20_no_to", 64'(timeout), 64'd0);

    // Disable mid-period
    en = 1'b0;
    @(negedge clk);
    check("dis_valid", 64'(period_valid), 64'd0);
    check("dis_locked", 64'(locked), 64'd0);
    check("dis_timeout", 64'(timeout), 64'd0);
    check("dis_period_hold", 64'(period), 64'd20);
    check("dis_high_hold", 64'(high_time), 64'd1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    train(10, 1, 1);
    check("reen_period_hold", 64'(period), 64'd20);
    expect_v(10, 1, 0, 0); expect_v(10, 1, 0, 1);
    train(10, 1, 2);
    max_period = '0;
    repeat (30) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
